// File: rtl/mfp_timer_pkg.sv
// Shared encodings for the MFP-style timer bank: mode values, ctrl bit positions,
// prescaler divisor table and the stored per-channel control layout.
package mfp_timer_pkg;

    localparam logic [3:0] MODE_STOP  = 4'd0;
    localparam logic [3:0] MODE_EVENT = 4'd8;

    localparam int unsigned CTRL_FORCE_BIT = 4;
    localparam int unsigned CTRL_CASC_BIT  = 5;
    localparam int unsigned CTRL_EDGE_BIT  = 6;

    localparam int unsigned PSC_W = 8;

    // Count source implied by a mode value
    typedef enum logic [1:0] {
        SrcStop,
        SrcDelay,
        SrcEvent,
        SrcPulse
    } src_e;

    // Stored control, laid out exactly as CTRL_O: {edge, cascade, mode}
    typedef struct packed {
        logic       edge_rise;
        logic       cascade;
        logic [3:0] mode;
    } ctrl_t;

    function automatic logic [PSC_W-1:0] psc_div(input logic [2:0] sel);
        logic [PSC_W-1:0] div;
        case (sel)
            3'd1:    div = 8'd4;
            3'd2:    div = 8'd10;
            3'd3:    div = 8'd16;
            3'd4:    div = 8'd50;
            3'd5:    div = 8'd64;
            3'd6:    div = 8'd100;
            3'd7:    div = 8'd200;
            default: div = 8'd1;
        endcase
        return div;
    endfunction

    function automatic src_e mode_src(input logic [3:0] mode);
        src_e src;
        if (mode == MODE_STOP) begin
            src = SrcStop;
        end else if (mode == MODE_EVENT) begin
            src = SrcEvent;
        end else if (mode[3]) begin
            src = SrcPulse;
        end else begin
            src = SrcDelay;
        end
        return src;
    endfunction

endpackage

// File: rtl/mfp_timer_chan.sv
// One timer channel: input synchronisers, prescaler, down-counter with reload,
// toggle output, timeout pulse and bus read snapshot.
module mfp_timer_chan
    import mfp_timer_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter bit          CASC_EN = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ds_i,
    input  logic             dat_we_i,
    input  logic [CNT_W-1:0] dat_i,
    input  logic             ctrl_we_i,
    input  logic [6:0]       ctrl_i,
    input  logic             xclk_i,
    input  logic             t_i,
    input  logic             casc_i,
    output logic [CNT_W-1:0] snap_o,
    output logic [5:0]       ctrl_o,
    output logic             t_o,
    output logic             timeout_o,
    output logic             delay_mode_o
);

    // [0],[1] form the synchroniser, [2] holds the previous synchronised level
    logic [2:0]       xclk_sync_q, xclk_sync_d;
    logic [2:0]       trig_sync_q, trig_sync_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             t_q, t_d;
    logic             timeout_q, timeout_d;

    src_e             src;
    logic             xclk_rise;
    logic             trig_lvl;
    logic             trig_prev;
    logic             trig_active;
    logic             trig_edge;
    logic             casc_on;
    logic             psc_run;
    logic             psc_wrap;
    logic [PSC_W-1:0] psc_lim;
    logic             count_en;
    logic             terminal;
    logic [CNT_W-1:0] reload;

    always_comb begin
        src         = mode_src(ctrl_q.mode);
        xclk_rise   = xclk_sync_q[1] & ~xclk_sync_q[2];
        trig_lvl    = trig_sync_q[1];
        trig_prev   = trig_sync_q[2];
        trig_active = ctrl_q.edge_rise ? trig_lvl : ~trig_lvl;
        trig_edge   = ctrl_q.edge_rise ? (trig_lvl & ~trig_prev) : (~trig_lvl & trig_prev);
        casc_on     = CASC_EN && ctrl_q.cascade && (src != SrcStop);
        psc_lim     = psc_div(ctrl_q.mode[2:0]) - 8'd1;
        psc_run     = !casc_on && xclk_rise &&
                      ((src == SrcDelay) || ((src == SrcPulse) && trig_active));
        psc_wrap    = psc_run && (psc_q == psc_lim);

        case (src)
            SrcStop:  count_en = 1'b0;
            SrcEvent: count_en = trig_edge;
            default:  count_en = psc_wrap;
        endcase
        if (casc_on) begin
            count_en = casc_i;
        end

        terminal = count_en && (cnt_q == CNT_W'(1));
        // A reload coinciding with a data write must pick up the new value
        reload   = dat_we_i ? dat_i : data_q;
    end

    always_comb begin
        xclk_sync_d = {xclk_sync_q[1:0], xclk_i};
        trig_sync_d = {trig_sync_q[1:0], t_i};
        data_d      = dat_we_i ? dat_i : data_q;
        snap_d      = ds_i ? cnt_q : snap_q;
        timeout_d   = terminal;

        ctrl_d = ctrl_q;
        if (ctrl_we_i) begin
            ctrl_d.edge_rise = ctrl_i[CTRL_EDGE_BIT];
            ctrl_d.cascade   = ctrl_i[CTRL_CASC_BIT];
            ctrl_d.mode      = ctrl_i[3:0];
        end

        cnt_d = cnt_q;
        if (count_en) begin
            cnt_d = terminal ? reload : cnt_q - CNT_W'(1);
        end else if (dat_we_i && (src == SrcStop)) begin
            cnt_d = dat_i;
        end

        if ((src == SrcStop) || casc_on) begin
            psc_d = '0;
        end else if (psc_run) begin
            psc_d = psc_wrap ? '0 : psc_q + 8'd1;
        end else begin
            psc_d = psc_q;
        end
        if (ctrl_we_i && (ctrl_i[3:0] != ctrl_q.mode)) begin
            psc_d = '0;
        end

        t_d = t_q ^ terminal;
        if (ctrl_we_i && ctrl_i[CTRL_FORCE_BIT]) begin
            t_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            xclk_sync_q <= '0;
            trig_sync_q <= '0;
            ctrl_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            snap_q      <= '0;
            psc_q       <= '0;
            t_q         <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            xclk_sync_q <= xclk_sync_d;
            trig_sync_q <= trig_sync_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            psc_q       <= psc_d;
            t_q         <= t_d;
            timeout_q   <= timeout_d;
        end
    end

    assign snap_o       = snap_q;
    assign ctrl_o       = ctrl_q;
    assign t_o          = t_q;
    assign timeout_o    = timeout_q;
    assign delay_mode_o = (src == SrcDelay);

endmodule

// File: rtl/mfp_timer_bank.sv
// Bank of MFP68901-style timers: address decode for writes and combinational
// read muxes around CHANNELS timer channels, each cascadable from its lower neighbour.
module mfp_timer_bank
    import mfp_timer_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned CH_W     = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                DS,
    input  logic [CH_W-1:0]     ADDR,
    input  logic                DAT_WE,
    input  logic [CNT_W-1:0]    DAT_I,
    output logic [CNT_W-1:0]    DAT_O,
    input  logic                CTRL_WE,
    input  logic [6:0]          CTRL_I,
    output logic [5:0]          CTRL_O,
    input  logic                XCLK_I,
    input  logic [CHANNELS-1:0] T_I,
    output logic [CHANNELS-1:0] T_O,
    output logic [CHANNELS-1:0] TIMEOUT,
    output logic [CHANNELS-1:0] DELAY_MODE
);

    logic [CHANNELS-1:0] sel;
    logic [CHANNELS-1:0] casc_in;
    logic [CNT_W-1:0]    snap    [CHANNELS];
    logic [5:0]          ctrl_rd [CHANNELS];

    // Out-of-range addresses match no channel, so writes drop and reads give 0
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            sel[i] = (ADDR == CH_W'(i));
        end
    end

    // Channel 0 has no upstream neighbour
    assign casc_in = TIMEOUT << 1;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        mfp_timer_chan #(
            .CNT_W  (CNT_W),
            .CASC_EN(g > 0)
        ) u_chan (
            .clk_i       (CLK),
            .rst_ni      (RST_N),
            .ds_i        (DS),
            .dat_we_i    (DAT_WE & sel[g]),
            .dat_i       (DAT_I),
            .ctrl_we_i   (CTRL_WE & sel[g]),
            .ctrl_i      (CTRL_I),
            .xclk_i      (XCLK_I),
            .t_i         (T_I[g]),
            .casc_i      (casc_in[g]),
            .snap_o      (snap[g]),
            .ctrl_o      (ctrl_rd[g]),
            .t_o         (T_O[g]),
            .timeout_o   (TIMEOUT[g]),
            .delay_mode_o(DELAY_MODE[g])
        );
    end

    always_comb begin
        DAT_O  = '0;
        CTRL_O = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel[i]) begin
                DAT_O  = snap[i];
                CTRL_O = ctrl_rd[i];
            end
        end
    end

endmodule
